step_seq_arbiter: RTL and testbench

- Shares one 4-phase output sequencer (codes 1,2,3,4 on `y`) among NREQ requesters using round-robin.
- Each granted requester gets one complete phase burst P0..P3.
- A per-requester control bit, latched at grant, selects whether phase P2 runs or is skipped.
- Sits between client request logic and the shared 3-bit `y` command bus.

---
 rtl/step_seq_defs.sv | 35 +++
 rtl/rr_pick.sv | 30 +++
 rtl/step_seq_arbiter.sv | 137 +++++++++++++
 tb/tb_step_seq_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/step_seq_defs.sv
// Shared encodings for the step sequencer arbiter family.
// State codes, y command codes and counter width.
package step_seq_defs;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_P0   = 3'd1,
      S_P1   = 3'd2,
      S_P2   = 3'd3,
      S_P3   = 3'd4
   } state_t;

   localparam logic [2:0] Y_IDLE = 3'd0;
   localparam logic [2:0] Y_P0   = 3'd1;
   localparam logic [2:0] Y_P1   = 3'd2;
   localparam logic [2:0] Y_P2   = 3'd3;
   localparam logic [2:0] Y_P3   = 3'd4;

   localparam int CNTW = 4;

   function automatic logic [2:0] state_to_y(state_t s);
      logic [2:0] r;
      r = Y_IDLE;
      unique case (s)
         S_IDLE: r = Y_IDLE;
         S_P0:   r = Y_P0;
         S_P1:   r = Y_P1;
         S_P2:   r = Y_P2;
         S_P3:   r = Y_P3;
         default: r = Y_IDLE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request
// searching upward from last+1, wrapping.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDXW = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] last,
   output logic [NREQ-1:0] onehot,
   output logic [IDXW-1:0] idx,
   output logic            valid
);

   always_comb begin
      int j;
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      j      = 0;
      for (int i = 0; i < NREQ; i++) begin
         j = (int'(last) + 1 + i) % NREQ;
         if (!valid && req[j]) begin
            valid     = 1'b1;
            idx       = IDXW'(j);
            onehot[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/step_seq_arbiter.sv
// Round-robin arbiter sharing one 4-phase y sequencer;
// each winner runs P0..P3 with P2 gated by its latched ctl bit.
module step_seq_arbiter
   import step_seq_defs::*;
#(
   parameter int NREQ         = 4,
   parameter int IDXW         = 2,
   parameter int PHASE_CYCLES = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] ctl,
   output logic [NREQ-1:0] gnt,
   output logic [2:0]      y,
   output logic [NREQ-1:0] done,
   output logic            busy
);

   state_t            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [IDXW-1:0]   widx_q, widx_d;
   logic [IDXW-1:0]   last_q, last_d;
   logic              ctl_q, ctl_d;

   logic [IDXW-1:0]   pick_last;
   logic [NREQ-1:0]   pick_oh;
   logic [IDXW-1:0]   pick_idx;
   logic              pick_valid;
   logic              last_cycle;
   logic              start;

   // At the end of P3 the pointer has just moved to the current winner.
   assign pick_last = (state_q == S_P3) ? widx_q : last_q;

   rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_pick (
      .req    (req),
      .last   (pick_last),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   assign last_cycle = (cnt_q == CNTW'(PHASE_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         gnt_q   <= '0;
         widx_q  <= '0;
         last_q  <= IDXW'(NREQ - 1);
         ctl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         widx_q  <= widx_d;
         last_q  <= last_d;
         ctl_q   <= ctl_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      widx_d  = widx_q;
      last_d  = last_q;
      ctl_d   = ctl_q;
      start   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            start = pick_valid;
         end
         S_P0: begin
            if (last_cycle) begin
               state_d = S_P1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         S_P1: begin
            if (last_cycle) begin
               state_d = ctl_q ? S_P2 : S_P3;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         S_P2: begin
            if (last_cycle) begin
               state_d = S_P3;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         S_P3: begin
            if (last_cycle) begin
               last_d  = widx_q;
               cnt_d   = '0;
               state_d = S_IDLE;
               gnt_d   = '0;
               start   = pick_valid;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            gnt_d   = '0;
         end
      endcase

      if (start) begin
         state_d = S_P0;
         cnt_d   = '0;
         gnt_d   = pick_oh;
         widx_d  = pick_idx;
         ctl_d   = ctl[pick_idx];
      end
   end

   assign gnt  = gnt_q;
   assign y    = state_to_y(state_q);
   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_P3 && last_cycle) ? gnt_q : '0;

endmodule

// File: tb/tb_step_seq_arbiter.sv
// Directed bench for step_seq_arbiter: vector table on a
// PHASE_CYCLES=1 instance, hand sequences on a PHASE_CYCLES=3 one.
module tb_step_seq_arbiter;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] req   = '0;
   logic [3:0] ctl   = '0;

   logic [3:0] gnt1, done1, gnt3, done3;
   logic [2:0] y1, y3;
   logic       busy1, busy3;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   step_seq_arbiter #(
      .NREQ(4), .IDXW(2), .PHASE_CYCLES(1)
   ) dut1 (
      .clock(clock), .reset(reset), .req(req), .ctl(ctl),
      .gnt(gnt1), .y(y1), .done(done1), .busy(busy1)
   );

   step_seq_arbiter #(
      .NREQ(4), .IDXW(2), .PHASE_CYCLES(3)
   ) dut3 (
      .clock(clock), .reset(reset), .req(req), .ctl(ctl),
      .gnt(gnt3), .y(y3), .done(done3), .busy(busy3)
   );

   typedef struct {
      logic [3:0] req;
      logic [3:0] ctl;
      logic       rst;
      logic [3:0] gnt;
      logic [2:0] y;
      logic [3:0] done;
      logic       busy;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic [3:0] r, input logic [3:0] c,
                      input logic rs, input logic [3:0] g,
                      input logic [2:0] yy, input logic [3:0] d,
                      input logic b);
      vec_t v;
      v.req = r; v.ctl = c; v.rst = rs;
      v.gnt = g; v.y = yy; v.done = d; v.busy = b;
      tv.push_back(v);
   endtask

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] c,
                       input logic rs);
      req = r; ctl = c; reset = rs;
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [3:0] oh;
      // reset, single burst with P2
      add(4'h0, 4'h0, 1, 4'h0, 3'd0, 4'h0, 0);
      add(4'h1, 4'h1, 0, 4'h1, 3'd1, 4'h0, 1);
      add(4'h0, 4'h0, 0, 4'h1, 3'd2, 4'h0, 1);
      add(4'h0, 4'h0, 0, 4'h1, 3'd3, 4'h0, 1);
      add(4'h0, 4'h0, 0, 4'h1, 3'd4, 4'h1, 1);
      add(4'h0, 4'h0, 0, 4'h0, 3'd0, 4'h0, 0);
      // burst without P2
      add(4'h1, 4'h0, 0, 4'h1, 3'd1, 4'h0, 1);
      add(4'h0, 4'h0, 0, 4'h1, 3'd2, 4'h0, 1);
      add(4'h0, 4'h0, 0, 4'h1, 3'd4, 4'h1, 1);
      add(4'h0, 4'h0, 0, 4'h0, 3'd0, 4'h0, 0);
      // all requesting: back-to-back rotation
      add(4'h0, 4'h0, 1, 4'h0, 3'd0, 4'h0, 0);
      for (int k = 0; k < 4; k++) begin
         oh = 4'h1 << k;
         add(4'hF, 4'hF, 0, oh, 3'd1, 4'h0, 1);
         add(4'hF, 4'hF, 0, oh, 3'd2, 4'h0, 1);
         add(4'hF, 4'hF, 0, oh, 3'd3, 4'h0, 1);
         add(4'hF, 4'hF, 0, oh, 3'd4, oh, 1);
      end
      add(4'hF, 4'hF, 0, 4'h1, 3'd1, 4'h0, 1);
      // drop req[2] mid-burst, raise req[1]
      add(4'h0, 4'h0, 1, 4'h0, 3'd0, 4'h0, 0);
      add(4'h4, 4'h4, 0, 4'h4, 3'd1, 4'h0, 1);
      add(4'h4, 4'h4, 0, 4'h4, 3'd2, 4'h0, 1);
      add(4'h2, 4'h2, 0, 4'h4, 3'd3, 4'h0, 1);
      add(4'h2, 4'h2, 0, 4'h4, 3'd4, 4'h4, 1);
      add(4'h2, 4'h2, 0, 4'h2, 3'd1, 4'h0, 1);
      // reset during P2 restarts pointer
      add(4'h0, 4'h0, 1, 4'h0, 3'd0, 4'h0, 0);
      add(4'hF, 4'hF, 0, 4'h1, 3'd1, 4'h0, 1);
      add(4'hF, 4'hF, 0, 4'h1, 3'd2, 4'h0, 1);
      add(4'hF, 4'hF, 0, 4'h1, 3'd3, 4'h0, 1);
      add(4'hF, 4'hF, 1, 4'h0, 3'd0, 4'h0, 0);
      add(4'hA, 4'hA, 0, 4'h2, 3'd1, 4'h0, 1);

      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i].req, tv[i].ctl, tv[i].rst);
         check($sformatf("v%0d.gnt", i), int'(gnt1), int'(tv[i].gnt));
         check($sformatf("v%0d.y", i), int'(y1), int'(tv[i].y));
         check($sformatf("v%0d.done", i), int'(done1), int'(tv[i].done));
         check($sformatf("v%0d.busy", i), int'(busy1), int'(tv[i].busy));
      end

      // PHASE_CYCLES=3 with P2: each code held 3 cycles
      step(4'h0, 4'h0, 1);
      check("p3.rst_y", int'(y3), 0);
      check("p3.rst_busy", int'(busy3), 0);
      step(4'h4, 4'h4, 0);
      for (int k = 0; k < 12; k++) begin
         check($sformatf("p3a.y%0d", k), int'(y3), k / 3 + 1);
         check($sformatf("p3a.gnt%0d", k), int'(gnt3), 4);
         check($sformatf("p3a.done%0d", k), int'(done3),
               (k == 11) ? 4 : 0);
         check($sformatf("p3a.busy%0d", k), int'(busy3), 1);
         if (k < 11) step(4'h0, 4'h0, 0);
      end
      step(4'h0, 4'h0, 0);
      check("p3a.idle_y", int'(y3), 0);
      check("p3a.idle_gnt", int'(gnt3), 0);
      check("p3a.idle_busy", int'(busy3), 0);

      // PHASE_CYCLES=3 without P2: 1,1,1,2,2,2,4,4,4
      step(4'h4, 4'h0, 0);
      for (int k = 0; k < 9; k++) begin
         check($sformatf("p3b.y%0d", k), int'(y3),
               (k < 6) ? (k / 3 + 1) : 4);
         check($sformatf("p3b.done%0d", k), int'(done3),
               (k == 8) ? 4 : 0);
         if (k < 8) step(4'h0, 4'h4, 0);
      end
      step(4'h0, 4'h0, 0);
      check("p3b.idle_y", int'(y3), 0);
      check("p3b.idle_busy", int'(busy3), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
